// File: rtl/visor_bp_pkg.sv
// Shared definitions for the visor breakpoint/step engine: register map,
// CTRL/STATUS bit positions and the halt state type.
package visor_bp_pkg;

   localparam logic [5:0] REG_CTRL      = 6'd0;
   localparam logic [5:0] REG_STATUS    = 6'd1;
   localparam logic [5:0] REG_STEP      = 6'd2;
   localparam logic [5:0] REG_HALT_ADDR = 6'd3;
   localparam int         REG_BP_BASE   = 4;

   localparam int BP_OFS_ADDR = 0;
   localparam int BP_OFS_MASK = 1;
   localparam int BP_OFS_CFG  = 2;
   localparam int BP_OFS_HITS = 3;

   localparam int CTRL_RESUME = 0;
   localparam int CTRL_GEN    = 1;
   localparam int CTRL_CLR    = 2;

   localparam int ST_HALTED  = 0;
   localparam int ST_SKIP    = 1;
   localparam int ST_STEP    = 2;
   localparam int ST_IDX_LSB = 4;

   localparam logic [3:0] STEP_INDEX = 4'd15;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } bp_state_e;

   // Register index of field ofs within breakpoint idx's four-register window.
   function automatic logic [5:0] bp_reg(input int idx, input int ofs);
      return 6'(REG_BP_BASE + 4 * idx + ofs);
   endfunction

endpackage

// File: rtl/visor_bp_comparator.sv
// One masked breakpoint comparator: address/mask/config registers, pass
// countdown and saturating hit counter.
module visor_bp_comparator
   import visor_bp_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int PASS_WIDTH = 8,
   parameter int HIT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] addr_wdata_i,
   input  logic [PASS_WIDTH-1:0] pass_wdata_i,
   input  logic                  en_wdata_i,
   input  logic                  we_addr_i,
   input  logic                  we_mask_i,
   input  logic                  we_cfg_i,
   input  logic                  clr_hits_i,
   input  logic                  armed_i,
   input  logic [ADDR_WIDTH-1:0] code_addr_i,
   output logic                  trigger_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic [ADDR_WIDTH-1:0] mask_o,
   output logic [PASS_WIDTH-1:0] pass_o,
   output logic                  en_o,
   output logic [HIT_WIDTH-1:0]  hits_o
);

   logic [ADDR_WIDTH-1:0] addr_q, mask_q;
   logic [PASS_WIDTH-1:0] pass_q, pass_rem_q;
   logic                  en_q;
   logic [HIT_WIDTH-1:0]  hits_q;
   logic                  qmatch;

   // armed_i already folds in global enable, RUN state, execute cycle and skip.
   assign qmatch    = armed_i && en_q && (((code_addr_i ^ addr_q) & mask_q) == '0);
   assign trigger_o = qmatch && (pass_rem_q == '0);

   // NOTE: every register here uses <= so all updates see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         mask_q     <= '0;
         pass_q     <= '0;
         pass_rem_q <= '0;
         en_q       <= 1'b0;
         hits_q     <= '0;
      end else begin
         if (we_addr_i) addr_q <= addr_wdata_i;
         if (we_mask_i) mask_q <= addr_wdata_i;
         if (we_cfg_i) begin
            pass_q     <= pass_wdata_i;
            en_q       <= en_wdata_i;
            pass_rem_q <= pass_wdata_i;
         end else if (qmatch && (pass_rem_q != '0)) begin
            pass_rem_q <= pass_rem_q - PASS_WIDTH'(1);
         end
         if (clr_hits_i) hits_q <= '0;
         else if (qmatch && (hits_q != '1)) hits_q <= hits_q + HIT_WIDTH'(1);
      end
   end

   assign addr_o = addr_q;
   assign mask_o = mask_q;
   assign pass_o = pass_q;
   assign en_o   = en_q;
   assign hits_o = hits_q;

endmodule

// File: rtl/visor_bp_unit.sv
// Breakpoint and counted-step engine: halt FSM, step counter, priority
// encoder over NUM_BP comparators and the visor register read mux.
module visor_bp_unit
   import visor_bp_pkg::*;
#(
   parameter int NUM_BP     = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int PASS_WIDTH = 8,
   parameter int HIT_WIDTH  = 16
) (
   input  logic                  sysclk,
   input  logic                  sysreset_n,
   input  logic [5:0]            reg_addr,
   input  logic [15:0]           reg_wdata,
   input  logic                  reg_we,
   output logic [15:0]           reg_rdata,
   input  logic [ADDR_WIDTH-1:0] tg_code_addr,
   input  logic                  tg_enable_exec,
   output logic                  tg_hold,
   output logic                  bp_hit,
   output logic [3:0]            hit_index
);

   bp_state_e             state_q;
   logic                  global_en_q, skip_q;
   logic [15:0]           step_q, step_d;
   logic [ADDR_WIDTH-1:0] halt_addr_q;

   logic run, ctrl_we, step_we, skip_eff, armed, step_active, step_trig, any_trig;
   logic [3:0]            trig_idx;
   logic [NUM_BP-1:0]     bp_trig;
   logic [ADDR_WIDTH-1:0] bp_addr [NUM_BP];
   logic [ADDR_WIDTH-1:0] bp_mask [NUM_BP];
   logic [PASS_WIDTH-1:0] bp_pass [NUM_BP];
   logic                  bp_en   [NUM_BP];
   logic [HIT_WIDTH-1:0]  bp_hits [NUM_BP];

   assign run         = (state_q == RUN);
   assign ctrl_we     = reg_we && (reg_addr == REG_CTRL);
   assign step_we     = reg_we && (reg_addr == REG_STEP);
   assign step_active = run && (step_q != '0);
   // Skip suppresses matching only while the target still sits on the halt address.
   assign skip_eff    = skip_q && (tg_code_addr == halt_addr_q);
   assign armed       = global_en_q && run && tg_enable_exec && !skip_eff;

   for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
      visor_bp_comparator #(
         .ADDR_WIDTH (ADDR_WIDTH),
         .PASS_WIDTH (PASS_WIDTH),
         .HIT_WIDTH  (HIT_WIDTH)
      ) u_cmp (
         .clk          (sysclk),
         .rst_n        (sysreset_n),
         .addr_wdata_i (ADDR_WIDTH'(reg_wdata)),
         .pass_wdata_i (reg_wdata[8 +: PASS_WIDTH]),
         .en_wdata_i   (reg_wdata[0]),
         .we_addr_i    (reg_we && (reg_addr == bp_reg(i, BP_OFS_ADDR))),
         .we_mask_i    (reg_we && (reg_addr == bp_reg(i, BP_OFS_MASK))),
         .we_cfg_i     (reg_we && (reg_addr == bp_reg(i, BP_OFS_CFG))),
         .clr_hits_i   (ctrl_we && reg_wdata[CTRL_CLR]),
         .armed_i      (armed),
         .code_addr_i  (tg_code_addr),
         .trigger_o    (bp_trig[i]),
         .addr_o       (bp_addr[i]),
         .mask_o       (bp_mask[i]),
         .pass_o       (bp_pass[i]),
         .en_o         (bp_en[i]),
         .hits_o       (bp_hits[i])
      );
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      step_d    = step_q;
      step_trig = 1'b0;
      if (step_we) begin
         step_d = reg_wdata;
      end else if (run && tg_enable_exec && (step_q != '0)) begin
         step_d    = step_q - 16'd1;
         step_trig = (step_q == 16'd1);
      end
   end

   // Descending scan so the lowest triggering index is the last one written.
   always_comb begin
      any_trig = step_trig;
      trig_idx = STEP_INDEX;
      for (int i = NUM_BP - 1; i >= 0; i--) begin
         if (bp_trig[i]) begin
            any_trig = 1'b1;
            trig_idx = 4'(i);
         end
      end
   end

   always_ff @(posedge sysclk or negedge sysreset_n) begin
      if (!sysreset_n) begin
         state_q     <= RUN;
         tg_hold     <= 1'b0;
         bp_hit      <= 1'b0;
         hit_index   <= '0;
         halt_addr_q <= '0;
         global_en_q <= 1'b0;
         skip_q      <= 1'b0;
         step_q      <= '0;
      end else begin
         step_q <= step_d;
         if (ctrl_we) global_en_q <= reg_wdata[CTRL_GEN];
         if (skip_q && !skip_eff) skip_q <= 1'b0;
         case (state_q)
            RUN: begin
               if (any_trig) begin
                  state_q     <= HALTED;
                  tg_hold     <= 1'b1;
                  bp_hit      <= 1'b1;
                  hit_index   <= trig_idx;
                  halt_addr_q <= tg_code_addr;
               end
            end
            HALTED: begin
               if (ctrl_we && reg_wdata[CTRL_RESUME]) begin
                  state_q <= RUN;
                  tg_hold <= 1'b0;
                  bp_hit  <= 1'b0;
                  skip_q  <= 1'b1;
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

   always_comb begin
      reg_rdata = '0;
      case (reg_addr)
         REG_CTRL:      reg_rdata[CTRL_GEN] = global_en_q;
         REG_STATUS: begin
            reg_rdata[ST_IDX_LSB +: 4] = hit_index;
            reg_rdata[ST_STEP]         = step_active;
            reg_rdata[ST_SKIP]         = skip_q;
            reg_rdata[ST_HALTED]       = (state_q == HALTED);
         end
         REG_STEP:      reg_rdata = step_q;
         REG_HALT_ADDR: reg_rdata = 16'(halt_addr_q);
         default:       ;
      endcase
      for (int i = 0; i < NUM_BP; i++) begin
         if (reg_addr == bp_reg(i, BP_OFS_ADDR)) reg_rdata = 16'(bp_addr[i]);
         if (reg_addr == bp_reg(i, BP_OFS_MASK)) reg_rdata = 16'(bp_mask[i]);
         if (reg_addr == bp_reg(i, BP_OFS_CFG))  reg_rdata = 16'({bp_pass[i], 7'b0, bp_en[i]});
         if (reg_addr == bp_reg(i, BP_OFS_HITS)) reg_rdata = 16'(bp_hits[i]);
      end
   end

endmodule

// File: tb/tb_visor_bp_unit.sv
// Scoreboard bench for visor_bp_unit: stimulus queues expected halts and
// register reads, a negedge monitor pops and compares them.
module tb_visor_bp_unit;

   logic        sysclk         = 1'b0;
   logic        sysreset_n     = 1'b0;
   logic [5:0]  reg_addr       = '0;
   logic [15:0] reg_wdata      = '0;
   logic        reg_we         = 1'b0;
   logic [15:0] reg_rdata;
   logic [15:0] tg_code_addr   = '0;
   logic        tg_enable_exec = 1'b0;
   logic        tg_hold, bp_hit;
   logic [3:0]  hit_index;

   typedef struct { int cyc; logic [3:0] idx; } halt_exp_t;
   typedef struct { string name; logic [15:0] val; } rd_exp_t;

   halt_exp_t halt_q[$];
   rd_exp_t   rd_q[$];
   int        n_cmp = 0;
   int        n_fail = 0;
   int        cyc = 0;
   logic      rd_req = 1'b0;
   logic      prev_hold = 1'b0;

   visor_bp_unit dut (
      .sysclk         (sysclk),
      .sysreset_n     (sysreset_n),
      .reg_addr       (reg_addr),
      .reg_wdata      (reg_wdata),
      .reg_we         (reg_we),
      .reg_rdata      (reg_rdata),
      .tg_code_addr   (tg_code_addr),
      .tg_enable_exec (tg_enable_exec),
      .tg_hold        (tg_hold),
      .bp_hit         (bp_hit),
      .hit_index      (hit_index)
   );

   always #5 sysclk = ~sysclk;
   always @(posedge sysclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
      end
   endtask

   // Monitor: register reads and tg_hold rising edges, both against queued expectations.
   always @(negedge sysclk) begin : monitor
      rd_exp_t   r;
      halt_exp_t h;
      if (rd_req) begin
         if (rd_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL read_underrun: read at cycle %0d with nothing queued", cyc);
         end else begin
            r = rd_q.pop_front();
            check(r.name, reg_rdata, r.val);
         end
      end
      if (sysreset_n && tg_hold && !prev_hold) begin
         if (halt_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_halt: tg_hold rose at cycle %0d hit_index %0d, none expected",
                     cyc, hit_index);
         end else begin
            h = halt_q.pop_front();
            check("halt_index", 16'(hit_index), 16'(h.idx));
            check("halt_cycle", 16'(cyc), 16'(h.cyc));
            check("halt_bp_hit", 16'(bp_hit), 16'd1);
         end
      end
      prev_hold = tg_hold;
   end

   task automatic tick();
      @(posedge sysclk);
      #2;
   endtask

   task automatic wr(input logic [5:0] a, input logic [15:0] d);
      reg_addr  = a;
      reg_wdata = d;
      reg_we    = 1'b1;
      tick();
      reg_we    = 1'b0;
   endtask

   task automatic rd(input logic [5:0] a, input logic [15:0] exp, input string name);
      rd_exp_t e;
      e.name = name;
      e.val  = exp;
      rd_q.push_back(e);
      reg_addr = a;
      rd_req   = 1'b1;
      tick();
      rd_req   = 1'b0;
   endtask

   // One execute cycle; when a halt is due, tg_hold must rise right after this edge.
   task automatic ex(input logic [15:0] a, input bit halt, input logic [3:0] idx);
      halt_exp_t h;
      if (halt) begin
         h.cyc = cyc + 1;
         h.idx = idx;
         halt_q.push_back(h);
      end
      tg_code_addr   = a;
      tg_enable_exec = 1'b1;
      tick();
      tg_enable_exec = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge sysclk);
      #2;
      check("rst_tg_hold", 16'(tg_hold), 16'd0);
      check("rst_bp_hit", 16'(bp_hit), 16'd0);
      check("rst_hit_index", 16'(hit_index), 16'd0);
      sysreset_n = 1'b1;
      tick();
      rd(6'd0, 16'h0000, "rst_ctrl");
      rd(6'd1, 16'h0000, "rst_status");
      rd(6'd3, 16'h0000, "rst_halt_addr");

      // Exact-match breakpoint 0 at 0x0040
      wr(6'd4, 16'h0040);
      wr(6'd5, 16'hFFFF);
      wr(6'd6, 16'h0001);
      wr(6'd0, 16'h0002);
      rd(6'd0, 16'h0002, "ctrl_global_en");
      rd(6'd6, 16'h0001, "bp0_cfg");
      rd(6'd20, 16'h0000, "unmapped_read");
      ex(16'h003F, 0, 4'd0);
      ex(16'h0040, 1, 4'd0);
      rd(6'd1, 16'h0001, "s1_status");
      rd(6'd3, 16'h0040, "s1_halt_addr");
      rd(6'd7, 16'h0001, "s1_hits0");

      // Resume: same address must not re-trigger until the target moves away
      wr(6'd0, 16'h0003);
      ex(16'h0040, 0, 4'd0);
      ex(16'h0040, 0, 4'd0);
      rd(6'd1, 16'h0002, "resume_skip_status");
      rd(6'd7, 16'h0001, "skip_hits0");
      ex(16'h0041, 0, 4'd0);
      ex(16'h0040, 1, 4'd0);
      rd(6'd7, 16'h0002, "rehalt_hits0");
      wr(6'd0, 16'h0003);

      // Masked breakpoint 1 with pass count 2
      wr(6'd6, 16'h0000);
      wr(6'd8, 16'h0100);
      wr(6'd9, 16'hFF00);
      wr(6'd10, 16'h0201);
      ex(16'h0105, 0, 4'd0);
      ex(16'h0110, 0, 4'd0);
      rd(6'd1, 16'h0000, "s2_status_run");
      ex(16'h0120, 1, 4'd1);
      rd(6'd11, 16'h0003, "s2_hits1");
      rd(6'd3, 16'h0120, "s2_halt_addr");
      rd(6'd1, 16'h0011, "s2_status");
      rd(6'd10, 16'h0201, "s2_cfg1");

      // bp0 and bp2 on the same address: lowest index wins
      wr(6'd10, 16'h0000);
      wr(6'd4, 16'h0200);
      wr(6'd6, 16'h0001);
      wr(6'd12, 16'h0200);
      wr(6'd13, 16'hFFFF);
      wr(6'd14, 16'h0001);
      wr(6'd0, 16'h0006);
      rd(6'd11, 16'h0000, "clr_hits1");
      rd(6'd7, 16'h0000, "clr_hits0");
      wr(6'd0, 16'h0003);
      ex(16'h0200, 1, 4'd0);
      rd(6'd7, 16'h0001, "s3_hits0");
      rd(6'd15, 16'h0001, "s3_hits2");
      rd(6'd3, 16'h0200, "s3_halt_addr");

      // Counted step of 3 execute cycles
      wr(6'd6, 16'h0000);
      wr(6'd14, 16'h0000);
      wr(6'd2, 16'h0003);
      rd(6'd2, 16'h0003, "step_load");
      wr(6'd0, 16'h0003);
      rd(6'd1, 16'h0006, "step_status_run");
      ex(16'h0300, 0, 4'd0);
      rd(6'd2, 16'h0002, "step_after_one");
      ex(16'h0302, 0, 4'd0);
      ex(16'h0304, 1, 4'd15);
      rd(6'd2, 16'h0000, "step_zero");
      rd(6'd3, 16'h0304, "step_halt_addr");
      rd(6'd1, 16'h00F1, "step_status_halt");

      // Matches while halted change nothing
      wr(6'd6, 16'h0001);
      ex(16'h0200, 0, 4'd0);
      ex(16'h0200, 0, 4'd0);
      rd(6'd7, 16'h0001, "halted_no_count");

      // Asynchronous reset while halted
      sysreset_n = 1'b0;
      #1;
      check("async_rst_tg_hold", 16'(tg_hold), 16'd0);
      check("async_rst_bp_hit", 16'(bp_hit), 16'd0);
      tick();
      tick();
      sysreset_n = 1'b1;
      tick();
      check("rst2_hit_index", 16'(hit_index), 16'd0);
      rd(6'd0, 16'h0000, "rst2_ctrl");
      rd(6'd1, 16'h0000, "rst2_status");
      rd(6'd2, 16'h0000, "rst2_step");
      rd(6'd3, 16'h0000, "rst2_halt_addr");
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            rd(6'(4 + 4 * i + j), 16'h0000, $sformatf("rst2_bp%0d_reg%0d", i, j));
         end
      end
      ex(16'h0200, 0, 4'd0);
      tick();
      tick();

      check("halt_queue_empty", 16'(halt_q.size()), 16'd0);
      check("read_queue_empty", 16'(rd_q.size()), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
